// File: rtl/pipediv_pkg.sv
// Shared widths, the per-operation flag bundle and datapath sizing for the
// pipelined divider.
package pipediv_pkg;

    localparam int DEF_DIVIDENDLEN = 16;
    localparam int DEF_DIVISORLEN  = 8;
    localparam int DEF_TAGLEN      = 4;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
        logic dbz;
        logic ovf;
        logic is_signed;
    } flags_t;

    // Partial remainder width: wide enough for the dividend plus a divisor shifted by N-1.
    function automatic int datapath_len(input int n, input int m);
        return n + m - 1;
    endfunction

endpackage

// File: rtl/pipediv_if.sv
// Operand/result bundle for the pipelined divider; master = producer/consumer
// side, slave = divider side. Results carry out_valid only, with no backpressure.
interface pipediv_if #(
    parameter int N = pipediv_pkg::DEF_DIVIDENDLEN,
    parameter int M = pipediv_pkg::DEF_DIVISORLEN,
    parameter int T = pipediv_pkg::DEF_TAGLEN
) ();

    logic         in_valid;
    logic         in_signed;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic [T-1:0] in_tag;
    logic         out_valid;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    logic [T-1:0] out_tag;

    modport master (
        output in_valid, in_signed, dividend, divisor, in_tag,
        input  out_valid, quotient, remainder, div_by_zero, overflow, out_tag
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, in_tag,
        output out_valid, quotient, remainder, div_by_zero, overflow, out_tag
    );

endinterface

// File: rtl/pipediv_slice.sv
// One restoring-division step: trial-subtract the shifted divisor magnitude and
// keep the difference when it does not go negative.
module pipediv_slice #(
    parameter int SHIFT = 0,
    parameter int N     = 16,
    parameter int M     = 8
) (
    input  logic [N+M-2:0] rem_in,
    input  logic [M-1:0]   dmag,
    output logic [N+M-2:0] rem_out,
    output logic           q_bit
);

    localparam int DP = pipediv_pkg::datapath_len(N, M);

    logic [DP:0] sub_val;
    logic [DP:0] diff;

    // Both operands are below 2^DP, so bit DP of the difference is its sign.
    always_comb begin
        sub_val = {{(DP + 1 - M){1'b0}}, dmag} << SHIFT;
        diff    = {1'b0, rem_in} - sub_val;
        q_bit   = ~diff[DP];
        rem_out = q_bit ? diff[DP-1:0] : rem_in;
    end

endmodule

// File: rtl/pipediv_sv.sv
// Pipelined restoring divider: stage 0 conditions operands, stages 1..N each
// resolve one quotient bit, stage N+1 applies signs and flags.
module pipediv_sv
    import pipediv_pkg::*;
#(
    parameter int DIVIDENDLEN = DEF_DIVIDENDLEN,
    parameter int DIVISORLEN  = DEF_DIVISORLEN,
    parameter int TAGLEN      = DEF_TAGLEN
) (
    input logic       clock,
    input logic       reset,
    input logic       hold,
    pipediv_if.slave  bus
);

    localparam int N  = DIVIDENDLEN;
    localparam int M  = DIVISORLEN;
    localparam int T  = TAGLEN;
    localparam int DP = datapath_len(N, M);

    typedef struct packed {
        logic          valid;
        logic [T-1:0]  tag;
        flags_t        flags;
        logic [N-1:0]  quo;
        logic [DP-1:0] rem;
        logic [M-1:0]  dmag;
    } stage_t;

    stage_t stage_q [0:N+1];
    stage_t stage_d [0:N+1];

    logic [DP-1:0] slice_rem [1:N];
    logic [N:1]    slice_bit;

    logic          a_neg;
    logic          b_neg;
    logic [N-1:0]  a_mag;
    logic [M-1:0]  b_mag;
    stage_t        fin;
    logic [N-1:0]  q_fix;
    logic [M-1:0]  r_mag;
    logic [M-1:0]  r_fix;

    for (genvar k = 1; k <= N; k++) begin : g_slice
        pipediv_slice #(.SHIFT(N - k), .N(N), .M(M)) u_slice (
            .rem_in  (stage_q[k-1].rem),
            .dmag    (stage_q[k-1].dmag),
            .rem_out (slice_rem[k]),
            .q_bit   (slice_bit[k])
        );
    end

    always_comb begin
        // Magnitudes are unsigned, so -2^(N-1) maps to 2^(N-1) without loss.
        a_neg = bus.in_signed & bus.dividend[N-1];
        b_neg = bus.in_signed & bus.divisor[M-1];
        a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        b_mag = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;

        stage_d[0]                 = '0;
        stage_d[0].valid           = bus.in_valid;
        stage_d[0].tag             = bus.in_tag;
        stage_d[0].flags.neg_q     = a_neg ^ b_neg;
        stage_d[0].flags.neg_r     = a_neg;
        stage_d[0].flags.dbz       = (bus.divisor == '0);
        stage_d[0].flags.ovf       = bus.in_signed
                                     && (bus.dividend == {1'b1, {(N-1){1'b0}}})
                                     && (bus.divisor == '1);
        stage_d[0].flags.is_signed = bus.in_signed;
        stage_d[0].rem             = {{(M-1){1'b0}}, a_mag};
        stage_d[0].dmag            = b_mag;

        for (int k = 1; k <= N; k++) begin
            stage_d[k]            = stage_q[k-1];
            stage_d[k].rem        = slice_rem[k];
            stage_d[k].quo[N-k]   = slice_bit[k];
        end

        // Quotient truncates toward zero; remainder follows the dividend sign.
        fin   = stage_q[N];
        r_mag = fin.rem[M-1:0];
        q_fix = fin.flags.neg_q ? (~fin.quo + 1'b1) : fin.quo;
        r_fix = fin.flags.neg_r ? (~r_mag + 1'b1) : r_mag;
        if (fin.flags.dbz) begin
            q_fix = '1;
            r_fix = '0;
        end
        stage_d[N+1]     = fin;
        stage_d[N+1].quo = q_fix;
        stage_d[N+1].rem = {{(DP-M){1'b0}}, r_fix};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= N + 1; i++) stage_q[i] <= '0;
        end else if (!hold) begin
            for (int i = 0; i <= N + 1; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign bus.out_valid   = stage_q[N+1].valid;
    assign bus.quotient    = stage_q[N+1].valid ? stage_q[N+1].quo : '0;
    assign bus.remainder   = stage_q[N+1].valid ? stage_q[N+1].rem[M-1:0] : '0;
    assign bus.div_by_zero = stage_q[N+1].valid & stage_q[N+1].flags.dbz;
    assign bus.overflow    = stage_q[N+1].valid & stage_q[N+1].flags.ovf;
    assign bus.out_tag     = stage_q[N+1].valid ? stage_q[N+1].tag : '0;

endmodule

// File: tb/tb_pipediv_sv.sv
// Directed bench for pipediv_sv: hand-computed vectors, a streamed run with
// holds, and a mid-flight reset, all cross-checked by an in-order scoreboard.
module tb_pipediv_sv;

    localparam int N   = 16;
    localparam int M   = 8;
    localparam int T   = 4;
    localparam int W   = T + 2 + N + M;
    localparam int LAT = N + 2;

    logic clock;
    logic reset;
    logic hold;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic adv_last = 1'b0;
    logic rst_last = 1'b1;
    logic mon_en = 1'b0;
    logic [W:0] snap = '0;

    logic [W-1:0] exp_q[$];
    int           exp_edge_q[$];

    pipediv_if #(.N(N), .M(M), .T(T)) bus ();

    pipediv_sv #(.DIVIDENDLEN(N), .DIVISORLEN(M), .TAGLEN(T)) dut (
        .clock (clock),
        .reset (reset),
        .hold  (hold),
        .bus   (bus)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation toward zero.
    function automatic logic [W-1:0] model(input logic sgn, input logic [N-1:0] a,
                                           input logic [M-1:0] b, input logic [T-1:0] tag);
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic dbz;
        logic ovf;
        int sa;
        int sb;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == '0) begin
            q = '1;
            r = '0;
            dbz = 1'b1;
        end else if (!sgn) begin
            q = a / {{(N-M){1'b0}}, b};
            r = M'(a % {{(N-M){1'b0}}, b});
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = N'(sa / sb);
            r = M'(sa % sb);
            ovf = (sa == -(1 << (N - 1))) && (sb == -1);
        end
        return {tag, dbz, ovf, q, r};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.out_tag, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder};
    endfunction

    // Scoreboard input side: record every operation the DUT should sample.
    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            exp_edge_q.delete();
            rst_last <= 1'b1;
            adv_last <= 1'b0;
        end else begin
            rst_last <= 1'b0;
            adv_last <= !hold;
            if (!hold) begin
                edge_cnt <= edge_cnt + 1;
                if (bus.in_valid) begin
                    exp_q.push_back(model(bus.in_signed, bus.dividend, bus.divisor, bus.in_tag));
                    exp_edge_q.push_back(edge_cnt + 1);
                end
            end
        end
    end

    // Scoreboard output side: in-order results, exact latency, frozen on hold, masking.
    always @(negedge clock) begin
        logic [W-1:0] e;
        int ed;
        if (mon_en) begin
            if (!rst_last && !adv_last) begin
                chk("hold_frozen", {bus.out_valid, observed()}, snap);
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", bus.out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    ed = exp_edge_q.pop_front();
                    chk("sb_result", observed(), e);
                    chk("sb_latency", edge_cnt, ed + LAT - 1);
                end
            end else begin
                chk("masked_outputs", observed(), '0);
            end
        end
        snap = {bus.out_valid, observed()};
    end

    // Driver tasks
    task automatic issue(input logic sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                         input logic [T-1:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_tag    = tag;
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic run_one(input string name, input logic sgn, input logic [N-1:0] a,
                           input logic [M-1:0] b, input logic [T-1:0] tag,
                           input logic [N-1:0] eq, input logic [M-1:0] er,
                           input logic edbz, input logic eovf);
        issue(sgn, a, b, tag);
        repeat (LAT - 1) @(posedge clock);
        @(negedge clock);
        chk({name, "_valid"}, bus.out_valid, 1'b1);
        chk({name, "_quotient"}, bus.quotient, eq);
        chk({name, "_remainder"}, bus.remainder, er);
        chk({name, "_dbz"}, bus.div_by_zero, edbz);
        chk({name, "_ovf"}, bus.overflow, eovf);
        chk({name, "_tag"}, bus.out_tag, tag);
    endtask

    initial begin
        reset         = 1'b1;
        hold          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.in_tag    = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_valid", bus.out_valid, 1'b0);
        chk("reset_outputs", observed(), '0);
        mon_en = 1'b1;

        // Directed vectors
        run_one("u_1000_7",   1'b0, 16'd1000, 8'd7,   4'd3, 16'h008E, 8'h06, 1'b0, 1'b0);
        run_one("s_m100_7",   1'b1, 16'hFF9C, 8'd7,   4'd1, 16'hFFF2, 8'hFE, 1'b0, 1'b0);
        run_one("s_100_m7",   1'b1, 16'h0064, 8'hF9,  4'd2, 16'hFFF2, 8'h02, 1'b0, 1'b0);
        run_one("s_dbz",      1'b1, 16'h1234, 8'h00,  4'd4, 16'hFFFF, 8'h00, 1'b1, 1'b0);
        run_one("u_dbz",      1'b0, 16'h1234, 8'h00,  4'd5, 16'hFFFF, 8'h00, 1'b1, 1'b0);
        run_one("s_ovf",      1'b1, 16'h8000, 8'hFF,  4'd6, 16'h8000, 8'h00, 1'b0, 1'b1);
        run_one("u_8000_ff",  1'b0, 16'h8000, 8'hFF,  4'd7, 16'h0080, 8'h80, 1'b0, 1'b0);
        run_one("s_7fff_m128", 1'b1, 16'h7FFF, 8'h80, 4'd8, 16'hFF01, 8'h7F, 1'b0, 1'b0);

        // Back-to-back stream with a 3-cycle hold while issuing (inputs must be ignored).
        for (int i = 0; i < 20; i++) begin
            if (i == 8) begin
                hold          = 1'b1;
                bus.in_valid  = 1'b1;
                bus.in_signed = 1'b1;
                bus.dividend  = 16'hDEAD;
                bus.divisor   = 8'h05;
                bus.in_tag    = 4'hF;
                repeat (3) @(posedge clock);
                #1 hold = 1'b0;
                bus.in_valid = 1'b0;
            end
            issue(1'($urandom_range(0, 1)), N'($urandom_range(0, 16'hFFFF)),
                  M'($urandom_range(0, 255)), T'(i));
        end
        // Hold again while results are being presented.
        repeat (4) @(posedge clock);
        #1 hold = 1'b1;
        repeat (3) @(posedge clock);
        #1 hold = 1'b0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clock);
        @(negedge clock);
        chk("stream_drained", exp_q.size(), 0);

        // Reset with 10 operations in flight.
        for (int i = 0; i < 10; i++) begin
            issue(1'($urandom_range(0, 1)), N'($urandom_range(1, 16'hFFFF)),
                  M'($urandom_range(1, 255)), T'(i));
        end
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk("post_reset_valid", bus.out_valid, 1'b0);
            chk("post_reset_outputs", observed(), '0);
        end
        run_one("after_reset", 1'b0, 16'd5000, 8'd13, 4'd9, 16'd384, 8'd8, 1'b0, 1'b0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
